reservoir_level_model: RTL and testbench
========================================

Name: reservoir_level_model

Overview:
- Cycle-based plant model of the reservoir, the other end of the water-level controller loop.
- Consumes the controller's flow-rate commands (fr2, fr1, fr0, dfr) and a user drain demand, integrates a water level, and drives the thermometer-coded level sensors s[2:0] back to the controller.
- Used in closed-loop testbenches and on-chip self-test of the controller.

Parameters:
- LEVEL_W, 10, width of the level accumulator.
- MAX_LEVEL, 1023, saturation ceiling; must be < 2**LEVEL_W.
- T1, 256, s[0] threshold.
- T2, 512, s[1] threshold.
- T3, 768, s[2] threshold; T1<T2<T3 required.
- R_FR, 8, inflow per tick for each asserted fr0/fr1/fr2.
- R_DFR, 4, extra inflow per tick when dfr asserted.
- TICK_DIV, 4, clock cycles per integration tick; must be >=1.
- HYST, 16, sensor release hysteresis; used only with the optional feature.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- fr2  in  1  flow-rate command bit 2.
- fr1  in  1  flow-rate command bit 1.
- fr0  in  1  flow-rate command bit 0.
- dfr  in  1  supplemental flow command.
- drain  in  8  outflow subtracted per tick.
- load_en  in  1  one-cycle strobe to force the level.
- load_level  in  LEVEL_W  value forced on load_en.
- s  out  3  sensor outputs, thermometer code, registered.
- level  out  LEVEL_W  current level, registered.
- overflow  out  1  sticky: a tick result exceeded MAX_LEVEL.
- underflow  out  1  sticky: a tick result went below 0.
- rising  out  1  trend FSM in RISING.
- falling  out  1  trend FSM in FALLING.

Behaviour:
- Reset (synchronous, active-high): level=0, s=000, tick_cnt=0, overflow=0, underflow=0, trend=STEADY with pending count 0, rising=0, falling=0. Reset overrides load_en.
- tick_cnt counts 0..TICK_DIV-1 and wraps. A tick occurs on the cycle where tick_cnt==TICK_DIV-1. First tick is the TICK_DIV-th rising edge after reset deasserts.
- Net on a tick, signed width LEVEL_W+2: net = R_FR*(fr0+fr1+fr2) + R_DFR*dfr - drain. Inputs are sampled on the tick cycle only.
- new = level + net, then saturated to [0, MAX_LEVEL].
- new>MAX_LEVEL: overflow<=1. new<0: underflow<=1. Both flags stay set until reset or load.
- s and level update on the same edge; s is computed from the saturated new level. s[0] = (lvl>=T1), s[1] = (lvl>=T2), s[2] = (lvl>=T3). Latency from tick edge to s is 0 cycles; s never changes between ticks.
- load_en has priority over a same-cycle tick:
  - level<=min(load_level, MAX_LEVEL); s recomputed from it.
  - tick_cnt<=0; overflow and underflow cleared.
  - trend<=STEADY with pending count cleared.
- Trend FSM, states STEADY/RISING/FALLING, evaluated on ticks only.
  - sign = +, - or 0 of the saturated delta (new level minus old level).
  - A transition to the state matching the sign requires 2 consecutive ticks with that same sign. A 1-bit pending register tracks the candidate sign.
  - A tick with the sign of the current state clears pending. A tick breaking a candidate run clears pending.
- Saturated-at-ceiling ticks give delta 0, so trend heads to STEADY.
- Outputs: rising=(state==RISING), falling=(state==FALLING).

Optional Feature:
- Macro RESERVOIR_SENSOR_HYST_EN.
- Defined: each sensor bit sets when lvl>=Tn. It clears only when lvl<Tn-HYST. Between those points the bit holds its previous value. Load recomputes bits from the loaded level with no hysteresis.
- Undefined: pure compare as above; HYST is ignored.

Test Plan:
- Reset, all inputs 0 for 40 cycles -> level=0, s=000, flags=0, rising=falling=0 throughout.
- fr2=fr1=fr0=dfr=1, drain=0 after reset -> level 28, 56, ... every 4 cycles. s=001 first at tick 10 (level 280). s=011 at tick 19 (532). s=111 at tick 28 (784). rising=1 from tick 2.
- load 1020, all fr=1, drain=0 -> next tick level=1023, overflow=1. Further ticks hold 1023; trend goes STEADY after 2 ticks; overflow stays 1.
- load 10, fr=0, drain=30 -> next tick level=0, underflow=1, s=000. Next load 300 -> underflow=0, s=001 on the following cycle.
- Rising state, then one tick with net -8, then net +8 -> remains RISING; falling never asserts.
- load_en on a tick cycle with net +28 -> level equals load_level (no +28), tick_cnt=0, next tick 4 cycles later. With RESERVOIR_SENSOR_HYST_EN: level 260->250 keeps s[0]=1; at 239 s[0]=0.

Source files
------------

// File: rtl/reservoir_level_model.sv
// reservoir_level_model: cycle-based plant model of the reservoir.
// Integrates the controller's flow commands and the drain demand into a
// saturated water level every TICK_DIV cycles and drives back the
// thermometer-coded level sensors. A trend FSM (STEADY/RISING/FALLING)
// follows the sign of the level change with a two-tick confirmation.
// Optional feature: define RESERVOIR_SENSOR_HYST_EN to give each sensor
// bit a release hysteresis of HYST below its threshold.
module reservoir_level_model #(
  parameter int LEVEL_W   = 10,
  parameter int MAX_LEVEL = 1023,
  parameter int T1        = 256,
  parameter int T2        = 512,
  parameter int T3        = 768,
  parameter int R_FR      = 8,
  parameter int R_DFR     = 4,
  parameter int TICK_DIV  = 4,
  parameter int HYST      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fr2,
  input  logic               fr1,
  input  logic               fr0,
  input  logic               dfr,
  input  logic [7:0]         drain,
  input  logic               load_en,
  input  logic [LEVEL_W-1:0] load_level,
  output logic [2:0]         s,
  output logic [LEVEL_W-1:0] level,
  output logic               overflow,
  output logic               underflow,
  output logic               rising,
  output logic               falling
);

  localparam int NW    = LEVEL_W + 2;
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [LEVEL_W-1:0] MAX_L = LEVEL_W'(MAX_LEVEL);
  localparam logic signed [NW-1:0] MAX_S = NW'(MAX_LEVEL);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

`ifdef RESERVOIR_SENSOR_HYST_EN
  localparam bit HYST_EN = 1'b1;
`else
  localparam bit HYST_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_STEADY  = 2'd0,
    ST_RISING  = 2'd1,
    ST_FALLING = 2'd2
  } trend_t;

  // Registered state
  logic [CNT_W-1:0]   tick_cnt_q;
  logic [LEVEL_W-1:0] level_q;
  logic [2:0]         s_q;
  logic               overflow_q, underflow_q;
  logic               rising_q, falling_q;
  trend_t             state_q;
  logic               pending_q;
  trend_t             cand_q;

  // Combinational next-state values
  logic                tick_c;
  logic [1:0]          fr_cnt_c;
  logic [NW-1:0]       inflow_c;
  logic signed [NW-1:0] net_c, sum_c;
  logic [LEVEL_W-1:0]  new_lvl_c, ld_lvl_c;
  logic                ovf_c, unf_c;
  logic [2:0]          s_tick_c;
  trend_t              dir_c;
  trend_t              state_d, cand_d;
  logic                pending_d;

  // Plain threshold compare: used on load and in the non-hysteresis build.
  function automatic logic [2:0] sens_cmp(input logic [LEVEL_W-1:0] l);
    int li;
    li = int'(l);
    return {li >= T3, li >= T2, li >= T1};
  endfunction

  // One sensor bit with release hysteresis: set at t, clear below t-HYST.
  function automatic logic hyst_bit(input int li, input int t, input logic prev);
    if (li >= t)             return 1'b1;
    else if (li < t - HYST)  return 1'b0;
    else                     return prev;
  endfunction

  function automatic logic [2:0] sens_hyst(input logic [LEVEL_W-1:0] l,
                                           input logic [2:0] prev);
    int li;
    li = int'(l);
    return {hyst_bit(li, T3, prev[2]), hyst_bit(li, T2, prev[1]),
            hyst_bit(li, T1, prev[0])};
  endfunction

  // Tick strobe, signed net flow and the saturated candidate level.
  always_comb begin
    tick_c    = (tick_cnt_q == TICK_LAST);
    fr_cnt_c  = {1'b0, fr0} + {1'b0, fr1} + {1'b0, fr2};
    inflow_c  = NW'(R_FR * int'(fr_cnt_c) + (dfr ? R_DFR : 0));
    net_c     = $signed(inflow_c) - $signed(NW'(drain));
    sum_c     = $signed(NW'(level_q)) + net_c;
    ovf_c     = 1'b0;
    unf_c     = 1'b0;
    if (sum_c[NW-1]) begin
      unf_c     = 1'b1;
      new_lvl_c = '0;
    end else if (sum_c > MAX_S) begin
      ovf_c     = 1'b1;
      new_lvl_c = MAX_L;
    end else begin
      new_lvl_c = sum_c[LEVEL_W-1:0];
    end
    s_tick_c = HYST_EN ? sens_hyst(new_lvl_c, s_q) : sens_cmp(new_lvl_c);
    ld_lvl_c = (load_level > MAX_L) ? MAX_L : load_level;
  end

  // Trend next state: a new direction must be seen on two consecutive ticks.
  always_comb begin
    if (new_lvl_c > level_q)      dir_c = ST_RISING;
    else if (new_lvl_c < level_q) dir_c = ST_FALLING;
    else                          dir_c = ST_STEADY;
    state_d   = state_q;
    pending_d = pending_q;
    cand_d    = cand_q;
    if (dir_c == state_q) begin
      pending_d = 1'b0;
    end else if (pending_q && dir_c == cand_q) begin
      state_d   = dir_c;
      pending_d = 1'b0;
    end else if (pending_q) begin
      // A different direction broke the candidate run.
      pending_d = 1'b0;
    end else begin
      pending_d = 1'b1;
      cand_d    = dir_c;
    end
  end

  // Level, sensors, sticky flags, tick counter and trend FSM registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q  <= '0;
      level_q     <= '0;
      s_q         <= 3'b000;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      state_q     <= ST_STEADY;
      pending_q   <= 1'b0;
      cand_q      <= ST_STEADY;
      rising_q    <= 1'b0;
      falling_q   <= 1'b0;
    end else if (load_en) begin
      tick_cnt_q  <= '0;
      level_q     <= ld_lvl_c;
      s_q         <= sens_cmp(ld_lvl_c);
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      state_q     <= ST_STEADY;
      pending_q   <= 1'b0;
      cand_q      <= ST_STEADY;
      rising_q    <= 1'b0;
      falling_q   <= 1'b0;
    end else if (tick_c) begin
      tick_cnt_q  <= '0;
      level_q     <= new_lvl_c;
      s_q         <= s_tick_c;
      if (ovf_c) overflow_q  <= 1'b1;
      if (unf_c) underflow_q <= 1'b1;
      state_q     <= state_d;
      pending_q   <= pending_d;
      cand_q      <= cand_d;
      rising_q    <= (state_d == ST_RISING);
      falling_q   <= (state_d == ST_FALLING);
    end else begin
      tick_cnt_q  <= tick_cnt_q + CNT_W'(1);
    end
  end

  assign s         = s_q;
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign rising    = rising_q;
  assign falling   = falling_q;

endmodule

// File: tb/tb_reservoir_level_model.sv
// Directed testbench for reservoir_level_model (default parameters,
// TICK_DIV=4). Outputs are sampled 1 time unit after the rising edge.
module tb_reservoir_level_model;

  localparam int LEVEL_W = 10;

  // Clock and reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic               fr2, fr1, fr0, dfr;
  logic [7:0]         drain;
  logic               load_en;
  logic [LEVEL_W-1:0] load_level;
  logic [2:0]         s;
  logic [LEVEL_W-1:0] level;
  logic               overflow, underflow, rising, falling;

  int n_checks = 0;
  int n_err    = 0;
  logic [LEVEL_W-1:0] exp_q[$];

  reservoir_level_model dut (
    .clk        (clk),
    .reset      (reset),
    .fr2        (fr2),
    .fr1        (fr1),
    .fr0        (fr0),
    .dfr        (dfr),
    .drain      (drain),
    .load_en    (load_en),
    .load_level (load_level),
    .s          (s),
    .level      (level),
    .overflow   (overflow),
    .underflow  (underflow),
    .rising     (rising),
    .falling    (falling)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_flow(input logic f2, input logic f1, input logic f0,
                          input logic d, input logic [7:0] dr);
    fr2 = f2; fr1 = f1; fr0 = f0; dfr = d; drain = dr;
  endtask

  task automatic do_load(input logic [LEVEL_W-1:0] v);
    load_en = 1'b1;
    load_level = v;
    cycles(1);
    load_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
  endtask

  initial begin
    logic [LEVEL_W-1:0] e;
    int bad;
    set_flow(0, 0, 0, 0, 8'd0);
    load_en = 1'b0;
    load_level = '0;

    // Reset state, idle inputs for 40 cycles
    do_reset();
    chk("reset_level", level, 0);
    chk("reset_s", s, 0);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      cycles(1);
      if ({level, s, overflow, underflow, rising, falling} !== '0) bad++;
    end
    chk("idle_outputs_nonzero_cycles", bad, 0);

    // Reset overrides load
    reset = 1'b1; load_en = 1'b1; load_level = 10'd500;
    cycles(1);
    chk("reset_over_load", level, 0);
    load_en = 1'b0;
    do_reset();

    // Full inflow: +28 per tick, thresholds crossed at ticks 10/19/28
    set_flow(1, 1, 1, 1, 8'd0);
    cycles(3);
    chk("before_first_tick", level, 0);
    cycles(1);
    chk("first_tick_level", level, 28);
    chk("first_tick_rising", rising, 0);
    for (int k = 2; k <= 30; k++) exp_q.push_back(LEVEL_W'(28 * k));
    for (int k = 2; k <= 30; k++) begin
      cycles(2);
      chk("hold_between_ticks", level, 28 * (k - 1));
      cycles(2);
      e = exp_q.pop_front();
      chk("ramp_level", level, e);
      chk("ramp_s", s, (k >= 28) ? 7 : (k >= 19) ? 3 : (k >= 10) ? 1 : 0);
      chk("ramp_rising", rising, 1);
      chk("ramp_falling", falling, 0);
      chk("ramp_overflow", overflow, 0);
    end

    // Ceiling saturation
    do_load(10'd1020);
    chk("load1020_level", level, 1020);
    chk("load1020_rising_cleared", rising, 0);
    cycles(4);
    chk("ceil_level", level, 1023);
    chk("ceil_overflow", overflow, 1);
    chk("ceil_s", s, 7);
    cycles(4);
    chk("ceil_hold_level", level, 1023);
    chk("ceil_hold_overflow", overflow, 1);
    chk("ceil_steady_rising", rising, 0);
    chk("ceil_steady_falling", falling, 0);

    // Floor saturation
    set_flow(0, 0, 0, 0, 8'd30);
    do_load(10'd10);
    chk("load10_ovf_cleared", overflow, 0);
    chk("load10_level", level, 10);
    cycles(4);
    chk("floor_level", level, 0);
    chk("floor_underflow", underflow, 1);
    chk("floor_s", s, 0);
    cycles(4);
    chk("floor_hold_underflow", underflow, 1);
    do_load(10'd300);
    chk("load300_underflow", underflow, 0);
    chk("load300_s", s, 1);
    chk("load300_level", level, 300);

    // Trend: rise, one negative blip, rise again, then confirmed fall
    set_flow(0, 0, 1, 0, 8'd0);
    do_load(10'd0);
    cycles(4);
    chk("trend_t1_level", level, 8);
    chk("trend_t1_rising", rising, 0);
    cycles(4);
    chk("trend_t2_rising", rising, 1);
    set_flow(0, 0, 0, 0, 8'd8);
    cycles(4);
    chk("blip_level", level, 8);
    chk("blip_rising", rising, 1);
    chk("blip_falling", falling, 0);
    set_flow(0, 0, 1, 0, 8'd0);
    cycles(4);
    chk("after_blip_level", level, 16);
    chk("after_blip_rising", rising, 1);
    chk("after_blip_falling", falling, 0);
    set_flow(0, 0, 0, 0, 8'd4);
    cycles(4);
    chk("fall1_level", level, 12);
    chk("fall1_rising", rising, 1);
    chk("fall1_falling", falling, 0);
    cycles(4);
    chk("fall2_level", level, 8);
    chk("fall2_rising", rising, 0);
    chk("fall2_falling", falling, 1);

    // Load on a tick cycle wins over the +28 step
    set_flow(1, 1, 1, 1, 8'd0);
    cycles(3);
    do_load(10'd100);
    chk("load_on_tick_level", level, 100);
    cycles(3);
    chk("load_on_tick_hold", level, 100);
    cycles(1);
    chk("post_load_tick_level", level, 128);
    chk("post_load_tick_rising", rising, 0);

    // Sensor release near T1
    set_flow(0, 0, 0, 0, 8'd10);
    do_load(10'd260);
    chk("load260_s", s, 1);
    cycles(4);
    chk("s_at_250_level", level, 250);
`ifdef RESERVOIR_SENSOR_HYST_EN
    chk("s_at_250_hyst", s, 1);
`else
    chk("s_at_250_plain", s, 0);
`endif
    drain = 8'd11;
    cycles(4);
    chk("s_at_239_level", level, 239);
    chk("s_at_239", s, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
